// File: rtl/vga_sync_rx.sv
// vga_sync_rx: receive side of a VGA sync link.
// Rebuilds pixel coordinates and an active-video flag from hsync/vsync
// edges, measures line and frame lengths, and declares lock after
// LOCK_FRAMES consecutive nominal frames.
//
// state  | meaning
// -------+---------------------------------------------------------------
// SEARCH | no frame reference yet; waiting for the first frame boundary
// TRACK  | counting consecutive good frames toward lock
// LOCKED | timing matches nominal; coordinates and inrange are valid
module vga_sync_rx #(
  parameter int Hs          = 96,
  parameter int Hb          = 48,
  parameter int Hd          = 640,
  parameter int Ht          = 800,
  parameter int Vs          = 2,
  parameter int Vb          = 33,
  parameter int Vd          = 480,
  parameter int Vt          = 525,
  parameter int LOCK_FRAMES = 2,
  parameter bit SYNC_ACT    = 1'b0
) (
  input  logic        clk_pix,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  output logic        locked,
  output logic        inrange,
  output logic [9:0]  h_cnt_o,
  output logic [9:0]  v_cnt_o,
  output logic [10:0] h_meas,
  output logic [9:0]  v_meas,
  output logic        err
);

  // Window bounds and nominal lengths, sized to the counters they meet.
  localparam logic [10:0] H_LO     = 11'(Hs + Hb);
  localparam logic [10:0] H_HI     = 11'(Hs + Hb + Hd);
  localparam logic [9:0]  V_LO     = 10'(Vs + Vb);
  localparam logic [9:0]  V_HI     = 10'(Vs + Vb + Vd);
  localparam logic [10:0] H_NOM    = 11'(Ht);
  localparam logic [9:0]  V_NOM    = 10'(Vt);
  localparam logic [10:0] H_TMO    = 11'(2 * Ht);
  localparam logic [10:0] H_SAT    = 11'h7FF;
  localparam logic [9:0]  V_SAT    = 10'h3FF;
  localparam logic [3:0]  GOOD_MAX = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  good, good_nx;
  logic        err_nx;

  logic        hs1, hs2, vs1, vs2;
  logic        h_edge, v_edge;
  logic [10:0] h_pos;
  logic [9:0]  v_pos;
  logic        h_seen, v_seen;
  logic        v_arm;
  logic        line_bad;

  logic [10:0] h_len;
  logic [9:0]  v_len;
  logic        frame_bnd;
  logic        line_bad_now;
  logic        frame_good;
  logic        timeout;
  logic [3:0]  good_inc;
  logic        win;

  // Two-flop input sampling, normalised so 1 always means "sync asserted".
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      hs1 <= 1'b0;
      hs2 <= 1'b0;
      vs1 <= 1'b0;
      vs2 <= 1'b0;
    end else begin
      hs1 <= (hsync == SYNC_ACT);
      hs2 <= hs1;
      vs1 <= (vsync == SYNC_ACT);
      vs2 <= vs1;
    end
  end

  assign h_edge = hs1 & ~hs2;
  assign v_edge = vs1 & ~vs2;

  // A v_edge arriving together with h_edge counts as armed, so that same
  // h_edge performs the frame reset.
  assign frame_bnd = h_edge & (v_arm | v_edge);

  // Length of the line/frame that ends on this edge (h_pos is clocks since
  // the last h_edge, so the line length is one more).
  assign h_len = (h_pos == H_SAT) ? H_SAT : h_pos + 11'd1;
  assign v_len = (v_pos == V_SAT) ? V_SAT : v_pos + 10'd1;

  // The first h_edge after reset has no valid start point, so it is not
  // measured and cannot flag a bad line.
  assign line_bad_now = h_edge & h_seen & (h_len != H_NOM);

  // The line closing the frame is included via line_bad_now, since
  // line_bad only picks it up on the following cycle.
  assign frame_good = v_seen & (v_len == V_NOM) & ~line_bad & ~line_bad_now;

  // h_pos passes through 2*Ht exactly once before saturating, which gives
  // a single timeout event per sync loss.
  assign timeout = ~h_edge & (h_pos == H_TMO);

  assign good_inc = good + 4'd1;

  // Horizontal position and line-length measurement.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      h_pos  <= '0;
      h_seen <= 1'b0;
      h_meas <= '0;
    end else begin
      if (h_edge) begin
        h_pos  <= '0;
        h_seen <= 1'b1;
        if (h_seen) begin
          h_meas <= h_len;
        end
      end else if (h_pos != H_SAT) begin
        h_pos <= h_pos + 11'd1;
      end
    end
  end

  // Vertical position, frame-length measurement and the vsync arm flag.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      v_pos  <= '0;
      v_seen <= 1'b0;
      v_meas <= '0;
      v_arm  <= 1'b0;
    end else begin
      if (frame_bnd) begin
        v_pos  <= '0;
        v_seen <= 1'b1;
        if (v_seen) begin
          v_meas <= v_len;
        end
      end else if (h_edge && (v_pos != V_SAT)) begin
        v_pos <= v_pos + 10'd1;
      end

      if (timeout || frame_bnd) begin
        v_arm <= 1'b0;
      end else if (v_edge) begin
        v_arm <= 1'b1;
      end
    end
  end

  // Sticky per-frame record of any off-nominal line.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      line_bad <= 1'b0;
    end else if (frame_bnd) begin
      line_bad <= 1'b0;
    end else if (line_bad_now) begin
      line_bad <= 1'b1;
    end
  end

  // Lock FSM state register; err is registered so it is a clean 1-clock pulse.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEARCH;
      good  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      good  <= good_nx;
      err   <= err_nx;
    end
  end

  // Lock FSM next state: timeout first, then frame boundary, then a bad
  // line while locked drops lock without waiting for the frame to end.
  always_comb begin
    state_nx = state;
    good_nx  = good;
    err_nx   = 1'b0;
    if (timeout) begin
      state_nx = SEARCH;
      good_nx  = '0;
      err_nx   = (state == LOCKED);
    end else if (frame_bnd) begin
      case (state)
        SEARCH: begin
          state_nx = TRACK;
          good_nx  = '0;
        end
        TRACK: begin
          if (frame_good) begin
            good_nx = good_inc;
            if (good_inc >= GOOD_MAX) begin
              state_nx = LOCKED;
            end
          end else begin
            good_nx = '0;
          end
        end
        LOCKED: begin
          if (!frame_good) begin
            err_nx   = 1'b1;
            state_nx = TRACK;
            good_nx  = '0;
          end
        end
        default: begin
          state_nx = SEARCH;
          good_nx  = '0;
        end
      endcase
    end else if (line_bad_now && (state == LOCKED)) begin
      err_nx   = 1'b1;
      state_nx = TRACK;
      good_nx  = '0;
    end
  end

  assign locked = (state == LOCKED);

  // Active window from the registered positions; coordinates are zero
  // whenever the pixel is not reported as active.
  assign win = (h_pos >= H_LO) && (h_pos < H_HI) &&
               (v_pos >= V_LO) && (v_pos < V_HI);

  assign inrange = win & locked;
  assign h_cnt_o = inrange ? 10'(h_pos - H_LO) : '0;
  assign v_cnt_o = inrange ? (v_pos - V_LO) : '0;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx with a scaled-down timing set so a frame is
// 32 x 16 = 512 clocks. Stimulus pushes expected pixels and lock/err events
// into queues; a negedge monitor pops and compares whenever the DUT shows
// inrange, an err pulse or a rising locked.
module tb_vga_sync_rx;

  localparam int HS = 4;
  localparam int HB = 4;
  localparam int HD = 16;
  localparam int HT = 32;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int VD = 8;
  localparam int VT = 16;

  localparam int EV_LOCK = 1;
  localparam int EV_ERR  = 2;

  logic        clk_pix = 1'b0;
  logic        rst_n   = 1'b0;
  logic        hsync   = 1'b1;
  logic        vsync   = 1'b1;
  logic        locked;
  logic        inrange;
  logic [9:0]  h_cnt_o;
  logic [9:0]  v_cnt_o;
  logic [10:0] h_meas;
  logic [9:0]  v_meas;
  logic        err;

  vga_sync_rx #(
    .Hs(HS), .Hb(HB), .Hd(HD), .Ht(HT),
    .Vs(VS), .Vb(VB), .Vd(VD), .Vt(VT),
    .LOCK_FRAMES(2), .SYNC_ACT(1'b0)
  ) dut (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .hsync   (hsync),
    .vsync   (vsync),
    .locked  (locked),
    .inrange (inrange),
    .h_cnt_o (h_cnt_o),
    .v_cnt_o (v_cnt_o),
    .h_meas  (h_meas),
    .v_meas  (v_meas),
    .err     (err)
  );

  always #5 clk_pix = ~clk_pix;

  int ncyc = 0;
  always @(posedge clk_pix) ncyc <= ncyc + 1;

  typedef struct {
    int due;
    int x;
    int y;
  } px_t;

  typedef struct {
    int kind;
    int due;
    int hm;
    int vm;
  } ev_t;

  px_t px_q[$];
  ev_t ev_q[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic fail_evt(input string name, input int val);
    n_chk++;
    n_err++;
    $display("FAIL %s: got %0d, expected none (cycle %0d)", name, val, ncyc);
  endtask

  task automatic push_px(input int due, input int x, input int y);
    px_t p;
    p.due = due;
    p.x   = x;
    p.y   = y;
    px_q.push_back(p);
  endtask

  task automatic push_ev(input int kind, input int due, input int hm, input int vm);
    ev_t e;
    e.kind = kind;
    e.due  = due;
    e.hm   = hm;
    e.vm   = vm;
    ev_q.push_back(e);
  endtask

  // Monitor: compare every DUT-presented pixel and event against the queues.
  logic locked_d = 1'b0;
  always @(negedge clk_pix) begin
    px_t p;
    ev_t e;
    int  kind;
    if (inrange) begin
      if (px_q.size() == 0) begin
        fail_evt("px_unexpected_x", int'(h_cnt_o));
      end else begin
        p = px_q.pop_front();
        chk("px_time", ncyc, p.due);
        chk("px_x", int'(h_cnt_o), p.x);
        chk("px_y", int'(v_cnt_o), p.y);
      end
    end
    while (px_q.size() > 0 && px_q[0].due < ncyc) begin
      p = px_q.pop_front();
      fail_evt("px_missed_due", p.due);
    end

    if (err || (locked && !locked_d)) begin
      kind = err ? EV_ERR : EV_LOCK;
      if (ev_q.size() == 0) begin
        fail_evt("evt_unexpected_kind", kind);
      end else begin
        e = ev_q.pop_front();
        chk("evt_kind", kind, e.kind);
        chk("evt_time", ncyc, e.due);
        chk("evt_h_meas", int'(h_meas), e.hm);
        chk("evt_v_meas", int'(v_meas), e.vm);
        chk("evt_locked", int'(locked), (e.kind == EV_LOCK) ? 1 : 0);
      end
    end
    while (ev_q.size() > 0 && ev_q[0].due < ncyc) begin
      e = ev_q.pop_front();
      fail_evt("evt_missed_due", e.due);
    end
    locked_d = locked;
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_locked"},  int'(locked),  0);
    chk({tag, "_inrange"}, int'(inrange), 0);
    chk({tag, "_h_cnt"},   int'(h_cnt_o), 0);
    chk({tag, "_v_cnt"},   int'(v_cnt_o), 0);
    chk({tag, "_h_meas"},  int'(h_meas),  0);
    chk({tag, "_v_meas"},  int'(v_meas),  0);
    chk({tag, "_err"},     int'(err),     0);
  endtask

  // One source frame. short_line gets HT-1 clocks (err expected at the next
  // line start); evt/evt_vm is the event expected at this frame's start;
  // rst_line pulses reset mid-line.
  task automatic do_frame(input int nlines, input int short_line, input bit px_in,
                          input int rst_line, input int evt, input int evt_vm,
                          output int last_start);
    bit px;
    px = px_in;
    last_start = 0;
    for (int l = 0; l < nlines; l++) begin
      int len;
      len = (l == short_line) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        @(negedge clk_pix);
        hsync = (h < HS) ? 1'b0 : 1'b1;
        vsync = (l < VS) ? 1'b0 : 1'b1;
        if (h == 0) last_start = ncyc;
        if (l == 0 && h == 0 && evt != 0) push_ev(evt, ncyc + 2, HT, evt_vm);
        if (short_line >= 0 && l == short_line + 1 && h == 0)
          push_ev(EV_ERR, ncyc + 2, HT - 1, VT);
        if (px && h >= HS + HB && h < HS + HB + HD && l >= VS + VB && l < VS + VB + VD)
          push_px(ncyc + 2, h - HS - HB, l - VS - VB);
        if (l == rst_line && h == 10) begin
          #2 rst_n = 1'b0;
          #1 chk_zero("midrst");
          px_q.delete();
          px = 1'b0;
          #1 rst_n = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int ls;
    repeat (3) @(negedge clk_pix);
    chk_zero("init");
    rst_n = 1'b1;

    // Nominal acquisition: lock at the third frame boundary.
    do_frame(VT, -1, 1'b0, -1, 0, 0, ls);
    do_frame(VT, -1, 1'b0, -1, 0, 0, ls);
    do_frame(VT, -1, 1'b1, -1, EV_LOCK, VT, ls);
    do_frame(VT, -1, 1'b1, -1, 0, 0, ls);

    // Short line while locked, then relock after two good frames.
    do_frame(VT, 13, 1'b1, -1, 0, 0, ls);
    do_frame(VT, -1, 1'b0, -1, 0, 0, ls);
    do_frame(VT, -1, 1'b0, -1, 0, 0, ls);
    do_frame(VT, -1, 1'b1, -1, EV_LOCK, VT, ls);

    // Short frame (VT-1 lines) while locked.
    do_frame(VT - 1, -1, 1'b1, -1, 0, 0, ls);
    do_frame(VT, -1, 1'b0, -1, EV_ERR, VT - 1, ls);
    do_frame(VT, -1, 1'b0, -1, 0, 0, ls);
    do_frame(VT, -1, 1'b1, -1, EV_LOCK, VT, ls);

    // Sync loss: timeout 2*HT clocks after the last h_edge, a single err.
    push_ev(EV_ERR, ls + 2 * HT + 3, HT, VT);
    repeat (150) @(negedge clk_pix);
    chk("loss_locked", int'(locked), 0);
    do_frame(VT, -1, 1'b0, -1, 0, 0, ls);
    do_frame(VT, -1, 1'b0, -1, 0, 0, ls);
    do_frame(VT, -1, 1'b1, -1, EV_LOCK, VT, ls);

    // Reset mid-frame (line 5), then reacquire in three boundaries.
    do_frame(VT, -1, 1'b1, 5, 0, 0, ls);
    do_frame(VT, -1, 1'b0, -1, 0, 0, ls);
    do_frame(VT, -1, 1'b0, -1, 0, 0, ls);
    do_frame(VT, -1, 1'b1, -1, EV_LOCK, VT, ls);

    repeat (5) @(negedge clk_pix);
    chk("final_locked", int'(locked), 1);
    chk("final_px_left", px_q.size(), 0);
    chk("final_evt_left", ev_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
